multiplier_scheduler: RTL
=========================

# multiplier_scheduler

Shares one 4x4 combinational multiplier (`multiplier_combinational` or `multiplier_array`) between two requesters. Each request is accepted with a grant pulse, and its operands are driven to the multiplier for a programmable settle time. The product is captured in a register and held with a valid flag until the owning requester acknowledges it. The block sits between the switch/button front end and the multiplier, and feeds `seven_segment_display` or other consumers.

## Interface
- `SETTLE_CYCLES`, default 1: cycles the operands are held at the multiplier before the product is sampled. Legal range 1..15.
- `clock` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `request_1`, `request_2` input 1 each: level request. Held with operands stable until the matching grant is seen.
- `a_1`, `b_1`, `a_2`, `b_2` input 4 each: operands of requester 1 and requester 2.
- `acknowledge_1`, `acknowledge_2` input 1 each: requester consumes its result.
- `grant_1`, `grant_2` output 1 each: one-cycle registered pulse; the request and operands were accepted.
- `valid_1`, `valid_2` output 1 each: `product` belongs to this requester and is valid.
- `product` output 8: registered result.
- `busy` output 1: high in any state other than IDLE.
- `mult_a`, `mult_b` output 4 each: registered operands driven to the shared multiplier.
- `mult_p` input 8: product returned from the shared multiplier.

## Operation
- States: IDLE, SETTLE, DELIVER. Internal state:
  - `owner`: 1 bit.
  - `priority`: 1 bit; the requester favoured on a tie.
  - 4-bit settle counter.

IDLE
- No request: stay in IDLE.
- Only one request high: that requester wins.
- Both high: the requester named by `priority` wins.
- On a win:
  - load `mult_a`/`mult_b` from the winner's operands;
  - set `owner`;
  - pulse `grant_owner`;
  - load the counter with `SETTLE_CYCLES`;
  - go to SETTLE.

SETTLE
- Counter decrements every cycle.
- On the edge where the counter equals 1:
  - `product` <= `mult_p`;
  - `valid_owner` <= 1;
  - go to DELIVER.
- `mult_a`/`mult_b` stay constant throughout SETTLE.

DELIVER
- `product` and `valid_owner` are held.
- On the edge where `acknowledge_owner` is sampled high:
  - `valid_owner` <= 0;
  - `priority` <= the non-owner (round-robin: the last served gets lowest priority);
  - go to IDLE.

General rules
- An acknowledge from the non-owner, or any acknowledge while its valid is low, is ignored.
- A request is not re-evaluated until IDLE. A request still high in IDLE after delivery counts as a new request.
- `product`, `mult_a` and `mult_b` keep their last values after acknowledge until they are next loaded.
- `grant_1`/`grant_2` are never high together. `valid_1`/`valid_2` are never high together.
- Arithmetic is unsigned. `product` is the full 8 bits of `mult_p`, with no truncation.

## Timing
- Reset values:
  - state IDLE, `priority` = requester 1, `owner` 0, counter 0;
  - `grant_1`, `grant_2`, `valid_1`, `valid_2`, `busy` = 0;
  - `product` = 8'h00, `mult_a` = `mult_b` = 4'h0.
- Reset mid-operation (SETTLE or DELIVER) aborts the operation. No valid is asserted and no grant is pending afterwards.
- Let E0 be the edge at which a request is sampled in IDLE:
  - grant is high for the cycle after E0;
  - `busy` is high from E0;
  - valid rises at edge E0+`SETTLE_CYCLES`.
- An acknowledge sampled at edge Ea drops valid and `busy` at Ea. The earliest next grant is at edge Ea+1.
- Minimum spacing between grants, with acknowledge held high: `SETTLE_CYCLES`+2 cycles.
- The shared multiplier must settle within `SETTLE_CYCLES` clock periods. Integration sets this parameter; the block does not check it.
- A request that falls before being sampled in IDLE is lost and produces no grant.

## Test plan
- Requester 1 only: a_1=3, b_1=5, `SETTLE_CYCLES`=1, acknowledge_1 tied high. Required:
  - grant_1 pulse the cycle after E0;
  - valid_1 and product=8'd15 after E1;
  - valid_1 low after E2;
  - busy high exactly 2 cycles.
- Both request at the first edge after reset: a_1=b_1=15, a_2=15, b_2=1, acknowledges tied high. Required:
  - requester 1 served first (product 225);
  - then requester 2 (product 15);
  - at the next simultaneous request, requester 1 is granted again only after requester 2 was served.
- Acknowledge delayed: acknowledge_1 held low 5 cycles while request_2 is high. Required:
  - valid_1 and product stay constant;
  - no grant_2 until one cycle after acknowledge_1;
  - acknowledge_2 pulsed during DELIVER of requester 1 is ignored.
- `SETTLE_CYCLES`=3, a_2=9, b_2=7. Required:
  - mult_a=9 and mult_b=7 stable for 3 cycles;
  - valid_2 rises at E0+3 with product=8'd63.
- `reset` asserted during SETTLE, then released with no requests. Required:
  - all outputs at reset values;
  - no valid ever rises;
  - priority = requester 1.
- Exhaustive sweep: all 256 operand pairs alternating between requesters, with random acknowledge delays of 0..4 cycles. Required:
  - every product equals a×b;
  - grant/valid exclusivity holds;
  - grant count equals valid count.

Source files
------------

// File: rtl/multiplier_scheduler_if.sv
// rtl/multiplier_scheduler_if.sv - requester handshake and shared-multiplier bus
// Purpose: bundles the two requester handshakes, the result bus and the
//   operand/product path to the shared 4x4 multiplier.
// Modports:
//   slave      - scheduler side: takes requests/operands/acks and mult_p,
//                drives grants, valids, product, busy and mult_a/mult_b.
//   master     - requester side, mirror of slave (multiplier path excluded).
//   multiplier - the shared combinational multiplier.
interface multiplier_scheduler_if;
  logic       request_1;
  logic       request_2;
  logic [3:0] a_1;
  logic [3:0] b_1;
  logic [3:0] a_2;
  logic [3:0] b_2;
  logic       acknowledge_1;
  logic       acknowledge_2;
  logic       grant_1;
  logic       grant_2;
  logic       valid_1;
  logic       valid_2;
  logic [7:0] product;
  logic       busy;
  logic [3:0] mult_a;
  logic [3:0] mult_b;
  logic [7:0] mult_p;

  modport slave (
    input  request_1, request_2, a_1, b_1, a_2, b_2,
    input  acknowledge_1, acknowledge_2, mult_p,
    output grant_1, grant_2, valid_1, valid_2, product, busy,
    output mult_a, mult_b
  );

  modport master (
    output request_1, request_2, a_1, b_1, a_2, b_2,
    output acknowledge_1, acknowledge_2,
    input  grant_1, grant_2, valid_1, valid_2, product, busy
  );

  modport multiplier (
    input  mult_a, mult_b,
    output mult_p
  );
endinterface

// File: rtl/multiplier_scheduler.sv
// rtl/multiplier_scheduler.sv - round-robin scheduler sharing one 4x4 multiplier between two requesters
// Purpose: grants one requester at a time, holds its operands on the shared
//   multiplier for SETTLE_CYCLES clocks, captures the product and holds it
//   with the owner's valid flag until the owner acknowledges.
// Ports:
//   clock - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - multiplier_scheduler_if.slave (requests, operands, acks,
//           grants, valids, product, busy, mult_a/mult_b out, mult_p in)
// Parameter:
//   SETTLE_CYCLES - clocks the operands are held before sampling mult_p (1..15)
module multiplier_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  multiplier_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    DELIVER = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;     // 0: requester 1, 1: requester 2
  logic       prio_q, prio_d;       // requester favoured on a tie, same encoding
  logic [3:0] count_q, count_d;
  logic       grant_1_q, grant_1_d;
  logic       grant_2_q, grant_2_d;
  logic       valid_1_q, valid_1_d;
  logic       valid_2_q, valid_2_d;
  logic [7:0] product_q, product_d;
  logic [3:0] mult_a_q, mult_a_d;
  logic [3:0] mult_b_q, mult_b_d;

  logic       win_2;
  logic       ack_owner;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    prio_d    = prio_q;
    count_d   = count_q;
    grant_1_d = 1'b0;
    grant_2_d = 1'b0;
    valid_1_d = valid_1_q;
    valid_2_d = valid_2_q;
    product_d = product_q;
    mult_a_d  = mult_a_q;
    mult_b_d  = mult_b_q;

    // Requester 2 wins when it is alone, or when both ask and it holds priority.
    win_2     = bus.request_2 & (~bus.request_1 | prio_q);
    // Only the owner's acknowledge can release the result.
    ack_owner = owner_q ? bus.acknowledge_2 : bus.acknowledge_1;

    case (state_q)
      IDLE: begin
        if (bus.request_1 || bus.request_2) begin
          owner_d   = win_2;
          grant_1_d = ~win_2;
          grant_2_d = win_2;
          mult_a_d  = win_2 ? bus.a_2 : bus.a_1;
          mult_b_d  = win_2 ? bus.b_2 : bus.b_1;
          count_d   = SETTLE_LOAD;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          product_d = bus.mult_p;
          valid_1_d = ~owner_q;
          valid_2_d = owner_q;
          state_d   = DELIVER;
        end
      end
      DELIVER: begin
        if (ack_owner) begin
          valid_1_d = 1'b0;
          valid_2_d = 1'b0;
          prio_d    = ~owner_q;   // last served drops to lowest priority
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      prio_q    <= 1'b0;
      count_q   <= 4'd0;
      grant_1_q <= 1'b0;
      grant_2_q <= 1'b0;
      valid_1_q <= 1'b0;
      valid_2_q <= 1'b0;
      product_q <= 8'h00;
      mult_a_q  <= 4'h0;
      mult_b_q  <= 4'h0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      prio_q    <= prio_d;
      count_q   <= count_d;
      grant_1_q <= grant_1_d;
      grant_2_q <= grant_2_d;
      valid_1_q <= valid_1_d;
      valid_2_q <= valid_2_d;
      product_q <= product_d;
      mult_a_q  <= mult_a_d;
      mult_b_q  <= mult_b_d;
    end
  end

  assign bus.grant_1 = grant_1_q;
  assign bus.grant_2 = grant_2_q;
  assign bus.valid_1 = valid_1_q;
  assign bus.valid_2 = valid_2_q;
  assign bus.product = product_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.mult_a  = mult_a_q;
  assign bus.mult_b  = mult_b_q;

endmodule
